// File: rtl/knn_topk_select.sv
// Streaming top-K selector: keeps the five nearest (distance, label) pairs by insertion sort.
// Optional macro KNN_TOPK_DIST_OUT_EN adds the nearest_dist / kth_dist outputs.
module knn_topk_select #(
    parameter int DIST_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              K_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIST_W-1:0] in_dist,
    input  logic              in_label,
    input  logic              in_last,
    output logic              class1,
    output logic              class2,
    output logic              class3,
    output logic              class4,
    output logic              class5,
    output logic              k_mode_out,
    output logic [2:0]        num_valid,
`ifdef KNN_TOPK_DIST_OUT_EN
    output logic [DIST_W-1:0] nearest_dist,
    output logic [DIST_W-1:0] kth_dist,
`endif
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t state, state_nxt;

    logic [4:0]        slot_valid, slot_label;
    logic [DIST_W-1:0] slot_dist [5];
    logic [4:0]        nxt_valid, nxt_label;
    logic [DIST_W-1:0] nxt_dist [5];
    logic [4:0]        beaten;
    logic [4:0]        class_q, class_nxt;
    logic              accept;

    assign accept   = in_valid && (state == LOAD);
    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (accept && in_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The bank is kept sorted with invalid slots at the tail, so beaten[] is a thermometer code.
    always_comb begin
        for (int i = 0; i < 5; i++)
            beaten[i] = !slot_valid[i] || (in_dist < slot_dist[i]);
    end

    // Strict less-than keeps earlier equal-distance samples ahead of the newcomer.
    always_comb begin
        nxt_valid = slot_valid;
        nxt_label = slot_label;
        for (int i = 0; i < 5; i++)
            nxt_dist[i] = slot_dist[i];
        if (beaten[0]) begin
            nxt_valid[0] = 1'b1;
            nxt_dist[0]  = in_dist;
            nxt_label[0] = in_label;
        end
        for (int i = 1; i < 5; i++) begin
            if (beaten[i] && beaten[i-1]) begin
                nxt_valid[i] = slot_valid[i-1];
                nxt_dist[i]  = slot_dist[i-1];
                nxt_label[i] = slot_label[i-1];
            end else if (beaten[i]) begin
                nxt_valid[i] = 1'b1;
                nxt_dist[i]  = in_dist;
                nxt_label[i] = in_label;
            end
        end
    end

    always_comb begin
        class_nxt = nxt_valid & nxt_label;
        if (!k_mode_out)
            class_nxt[4:3] = 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            slot_label <= '0;
            for (int i = 0; i < 5; i++)
                slot_dist[i] <= '1;
            class_q    <= '0;
            k_mode_out <= 1'b0;
            num_valid  <= '0;
        end else if (state == IDLE && start) begin
            slot_valid <= '0;
            slot_label <= '0;
            for (int i = 0; i < 5; i++)
                slot_dist[i] <= '1;
            class_q    <= '0;
            k_mode_out <= K_mode;
            num_valid  <= '0;
        end else if (accept) begin
            slot_valid <= nxt_valid;
            slot_label <= nxt_label;
            for (int i = 0; i < 5; i++)
                slot_dist[i] <= nxt_dist[i];
            class_q <= class_nxt;
            if (num_valid != 3'd5)
                num_valid <= num_valid + 3'd1;
        end
    end

    assign class1 = class_q[0];
    assign class2 = class_q[1];
    assign class3 = class_q[2];
    assign class4 = class_q[3];
    assign class5 = class_q[4];

`ifdef KNN_TOPK_DIST_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nearest_dist <= '1;
            kth_dist     <= '1;
        end else if (state == IDLE && start) begin
            nearest_dist <= '1;
            kth_dist     <= '1;
        end else if (accept) begin
            nearest_dist <= nxt_dist[0];
            kth_dist     <= k_mode_out ? nxt_dist[4] : nxt_dist[2];
        end
    end
`endif

endmodule

// File: tb/tb_knn_topk_select.sv
// Scoreboard bench for knn_topk_select: driver queues expected results, a monitor checks on done.
// Build with KNN_TOPK_DIST_OUT_EN defined to also check the distance outputs.
module tb_knn_topk_select;

    logic        clk = 1'b0;
    logic        rst_n, start, K_mode, in_valid, in_label, in_last;
    logic [15:0] in_dist;
    logic        in_ready, class1, class2, class3, class4, class5, k_mode_out, done, busy;
    logic [2:0]  num_valid;
`ifdef KNN_TOPK_DIST_OUT_EN
    logic [15:0] nearest_dist, kth_dist;
`endif

    typedef struct {
        logic [4:0]  cls;
        logic        k;
        logic [2:0]  nv;
        logic [15:0] nd;
        logic [15:0] kd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_passed = 0;

    always #5 clk = ~clk;

    knn_topk_select #(.DIST_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .K_mode(K_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
        .in_label(in_label), .in_last(in_last),
        .class1(class1), .class2(class2), .class3(class3), .class4(class4), .class5(class5),
        .k_mode_out(k_mode_out), .num_valid(num_valid),
`ifdef KNN_TOPK_DIST_OUT_EN
        .nearest_dist(nearest_dist), .kth_dist(kth_dist),
`endif
        .done(done), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            n_passed++;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("classes", {class5, class4, class3, class2, class1}, e.cls);
                check("k_mode_out", k_mode_out, e.k);
                check("num_valid", num_valid, e.nv);
`ifdef KNN_TOPK_DIST_OUT_EN
                check("nearest_dist", nearest_dist, e.nd);
                check("kth_dist", kth_dist, e.kd);
`endif
            end
        end
    end

    task automatic run_query(input logic k, input int n, input logic [15:0] d[8],
                             input logic l[8], input exp_t e, input bit poke_start);
        exp_q.push_back(e);
        @(negedge clk);
        start  = 1'b1;
        K_mode = k;
        @(negedge clk);
        start = 1'b0;
        check("in_ready_after_start", in_ready, 1'b1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_dist  = d[i];
            in_label = l[i];
            in_last  = (i == n - 1);
            // A start during LOAD must not relatch K_mode.
            if (poke_start && i == 1) begin
                start  = 1'b1;
                K_mode = ~k;
            end
            @(negedge clk);
            start = 1'b0;
            if (i < n - 1) check("no_early_done", done, 1'b0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("done_timing", done, 1'b1);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_not_ready", in_ready, 1'b0);
    endtask

    logic [15:0] d_main [8] = '{16'd40, 16'd10, 16'd30, 16'd20, 16'd50, 16'd5, 16'd60, 16'd0};
    logic        l_main [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] d_tie  [8] = '{16'd10, 16'd10, 16'd10, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    logic        l_tie  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] d_one  [8] = '{16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    logic        l_one  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    exp_t e_k5    = '{cls: 5'b11101, k: 1'b1, nv: 3'd5, nd: 16'd5,  kd: 16'd40};
    exp_t e_k3    = '{cls: 5'b00101, k: 1'b0, nv: 3'd5, nd: 16'd5,  kd: 16'd20};
    exp_t e_tie   = '{cls: 5'b00101, k: 1'b1, nv: 3'd3, nd: 16'd10, kd: 16'hFFFF};
    exp_t e_short = '{cls: 5'b00001, k: 1'b1, nv: 3'd1, nd: 16'd7,  kd: 16'hFFFF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; K_mode = 1'b0; in_valid = 1'b0;
        in_dist = '0; in_label = 1'b0; in_last = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_outputs", {class5, class4, class3, class2, class1, k_mode_out, num_valid}, '0);
`ifdef KNN_TOPK_DIST_OUT_EN
        check("rst_dists", {nearest_dist, kth_dist}, 32'hFFFF_FFFF);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_query(1'b1, 7, d_main, l_main, e_k5, 1'b0);
        // A sample offered in IDLE must be ignored.
        in_valid = 1'b1; in_dist = 16'd1; in_label = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_sample_ignored", {num_valid, class1}, {3'd5, 1'b1});

        run_query(1'b0, 7, d_main, l_main, e_k3, 1'b0);
        run_query(1'b1, 3, d_tie, l_tie, e_tie, 1'b1);
        run_query(1'b1, 1, d_one, l_one, e_short, 1'b0);

        // Abort a query after three accepts; no done pulse may follow.
        @(negedge clk);
        start = 1'b1; K_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_dist = d_main[i]; in_label = l_main[i];
            @(negedge clk);
        end
        check("pre_abort_count", num_valid, 3'd3);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_outputs", {class5, class4, class3, class2, class1, k_mode_out, num_valid}, '0);
        check("abort_ready_busy_done", {in_ready, busy, done}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
        end

        run_query(1'b1, 7, d_main, l_main, e_k5, 1'b0);

        @(negedge clk);
        check("all_expected_done_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/knn_topk_select.md
# knn_topk_select

Streaming top-K selector for the KNN classifier. It takes one (distance, label) pair per cycle from the distance-compute stage and keeps the five smallest distances in a sorted register bank using insertion sort. When the last sample arrives it presents the neighbour labels, nearest first, on class1..class5 for the majority-vote stage. K_mode is passed through so that the vote stage sees a consistent K.

## Interface
- DIST_W, 16, distance width in bits (unsigned)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse that begins a new query; accepted only in IDLE
- K_mode  in  1  0 = K3, 1 = K5; sampled on start
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample
- in_dist  in  DIST_W  distance of the sample to the query point
- in_label  in  1  binary class label of the sample
- in_last  in  1  marks the final sample of the query
- class1..class5  out  1 each  labels of the 1st..5th nearest neighbours
- k_mode_out  out  1  K_mode latched at start
- num_valid  out  3  occupied slots, 0..5
- done  out  1  one-cycle pulse; outputs are valid from this cycle on
- busy  out  1  high in LOAD

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE → LOAD on start.
  - LOAD → DONE on the accepted sample with in_last = 1.
  - DONE → IDLE unconditionally after 1 cycle.
- On start:
  - clear all 5 slots (valid = 0, dist = all ones, label = 0) and set num_valid = 0.
  - latch K_mode into k_mode_out.
- in_ready = 1 only in LOAD. A sample is accepted when in_valid && in_ready.
- Slot order: slot 1 holds the nearest distance, slot 5 the farthest kept.
- Insertion of an accepted sample, all in one cycle:
  - Slot i is "beaten" when !valid_i or in_dist < dist_i (strict).
  - The new sample goes into the lowest beaten slot. Slots below it shift down by one; slot 5's old content is discarded.
  - If no slot is beaten, the bank is unchanged.
- Ties: when distances are equal, the earlier-arriving sample stays ahead (stable ordering).
- num_valid increments on each accept and saturates at 5.
- Outputs:
  - class1..class5 are registered copies of the slot labels. Invalid slots read 0.
  - When k_mode_out = 0, class4 and class5 are forced to 0.
  - Outputs hold their values from DONE until the next start.
- start while in LOAD or DONE is ignored.
- in_valid asserted outside LOAD is ignored; no state changes.
- A query with a single sample (in_last on the first accept) is legal.

## Timing
- Reset values:
  - state = IDLE
  - in_ready = 0, busy = 0, done = 0
  - class1..class5 = 0, k_mode_out = 0, num_valid = 0
  - all slots invalid
- start in cycle t → LOAD and in_ready = 1 in cycle t+1.
- Throughput is 1 sample/cycle. No back-pressure inside LOAD.
- The sample accepted in cycle t is reflected in the slots and num_valid at t+1.
- Last sample accepted in cycle t → done = 1 in cycle t+1 with the final classN values → IDLE at t+2.
- A new start is accepted at t+2 at the earliest.
- Reset asserted mid-query: immediate return to reset values. No done pulse follows.

## Configuration
- KNN_TOPK_DIST_OUT_EN:
  - Defined: adds outputs nearest_dist [DIST_W-1:0] (slot 1 distance) and kth_dist [DIST_W-1:0] (distance of slot 3 when k_mode_out = 0, slot 5 otherwise).
    - Both outputs are registered and update with classN.
    - Both read all ones when the slot is invalid.
    - Both reset to all ones.
  - Undefined: neither port exists. All other behaviour is identical.

## Test plan
- K5, 7 samples with dist/label (40,1) (10,0) (30,1) (20,1) (50,0) (5,1) (60,0), last on the 7th:
  - done one cycle after the last sample.
  - class1..5 = 1,0,1,1,1 (dists 5,10,20,30,40).
  - num_valid = 5.
- K3, same stream:
  - class1..3 = 1,0,1; class4 = class5 = 0.
  - k_mode_out = 0.
- Tie: K5, samples (10,1) then (10,0) then (10,1):
  - class1..3 = 1,0,1 (stable order).
  - num_valid = 3; class4 = class5 = 0.
- Short query: K5, single sample (7,1) with in_last:
  - class1 = 1, others 0.
  - num_valid = 1.
  - done at start+2.
- Reset mid-query: rst_n low after 3 accepts:
  - all outputs 0, in_ready = 0, no done pulse.
  - A following start/query behaves as in the first scenario.
- With KNN_TOPK_DIST_OUT_EN defined, first scenario: nearest_dist = 5, kth_dist = 40.
